// File: rtl/entry_arb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | entry_arb_pkg                                                         |
// | FSM states, hex glyph table and thermometer helper for the arbiter.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package entry_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } arb_state_e;

  // Segments g..a, active-low, glyphs 0-9 A b C d E F
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [14:0] thermo(input logic [3:0] n);
    return 15'((16'd1 << n) - 16'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_bar_sweep.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | led_bar_sweep                                                         |
// | Registers the LED target; with ENTRY_ARB_SWEEP_EN it ramps the bar up |
// | one LED per SWEEP_CYCLES, otherwise the bar is the target itself.     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module led_bar_sweep #(
  parameter int LED_W        = 7,
  parameter int SWEEP_CYCLES = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LED_W-1:0] i_target,
  input  logic             i_restart,
  output logic [LED_W-1:0] o_led_bar
);

  logic [LED_W-1:0] r_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target <= '0;
    end else begin
      r_target <= i_target;
    end
  end

`ifdef ENTRY_ARB_SWEEP_EN
  localparam int CNT_W = (SWEEP_CYCLES > 1) ? $clog2(SWEEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SWEEP_CYCLES - 1);

  logic [LED_W-1:0] r_level;
  logic [CNT_W-1:0] r_cnt;

  // Counter parks at its last value so the first LED of a new rise lights on the next edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= '0;
      r_cnt   <= '0;
    end else if (i_restart) begin
      r_level <= '0;
      r_cnt   <= CNT_LAST;
    end else if (r_level >= r_target) begin
      r_level <= r_target;
      r_cnt   <= CNT_LAST;
    end else if (r_cnt == CNT_LAST) begin
      r_level <= (r_level << 1) | LED_W'(1);
      r_cnt   <= '0;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign o_led_bar = r_level;
`else
  logic        w_unused_restart;
  logic [31:0] w_unused_sweep;

  assign w_unused_restart = i_restart;
  assign w_unused_sweep   = SWEEP_CYCLES;
  assign o_led_bar        = r_target;
`endif

endmodule
`default_nettype wire

// File: rtl/multichannel_entry_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | multichannel_entry_arbiter                                            |
// | Round-robin arbiter with minimum hold over NUM_CH entry interfaces,   |
// | feature-conflict flag, hex digit and LED bar outputs.                 |
// | Optional: ENTRY_ARB_SWEEP_EN enables the LED bar sweep.               |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module multichannel_entry_arbiter
  import entry_arb_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int ID_W         = 3,
  parameter int FEAT_W       = 3,
  parameter int HOLD_CYCLES  = 50000000,
  parameter int SWEEP_CYCLES = 5000000
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [NUM_CH-1:0]        REQ_EN,
  input  logic [NUM_CH*ID_W-1:0]   REQ_ID,
  input  logic [NUM_CH*FEAT_W-1:0] REQ_FEAT,
  output logic [NUM_CH-1:0]        GRANT,
  output logic                     GNT_VALID,
  output logic [ID_W-1:0]          GNT_ID,
  output logic [FEAT_W-1:0]        GNT_FEAT,
  output logic                     CONFLICT,
  output logic [6:0]               SEG_N,
  output logic [(2**FEAT_W)-2:0]   LED_BAR
);

  localparam int IDX_W  = $clog2(NUM_CH);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int LED_W  = (2 ** FEAT_W) - 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0]  RR_RESET  = IDX_W'(NUM_CH - 1);

  arb_state_e        r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_rr_ptr, w_rr_nxt, w_rr_idx;
  logic [HOLD_W-1:0] r_hold, w_hold_nxt;
  logic [NUM_CH-1:0] w_valid, w_grant_nxt, r_grant;
  logic              w_holder_valid, w_others_valid, w_new_gnt, r_new_gnt;
  logic [ID_W-1:0]   w_id_nxt, r_gnt_id;
  logic [FEAT_W-1:0] w_feat_nxt, r_gnt_feat;
  logic              w_conflict, r_conflict, r_gnt_valid;
  logic [6:0]        r_seg_n;
  logic [LED_W-1:0]  w_led_target;
  int                w_best_dist;

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_valid
      assign w_valid[c] = REQ_EN[c] & (|REQ_ID[c*ID_W +: ID_W]) & (|REQ_FEAT[c*FEAT_W +: FEAT_W]);
    end
  endgenerate

  // r_grant is zero in IDLE, so "others" then means any valid channel
  assign w_holder_valid = |(w_valid & r_grant);
  assign w_others_valid = |(w_valid & ~r_grant);

  // Distance from rr_ptr+1; the current holder (== rr_ptr) is farthest
  always_comb begin
    w_rr_idx    = r_rr_ptr;
    w_best_dist = NUM_CH;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_valid[c] && (((c - int'(r_rr_ptr) - 1 + NUM_CH) % NUM_CH) < w_best_dist)) begin
        w_best_dist = (c - int'(r_rr_ptr) - 1 + NUM_CH) % NUM_CH;
        w_rr_idx    = IDX_W'(c);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_hold_nxt  = r_hold;
    w_new_gnt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_others_valid) begin
          w_state_nxt = ACTIVE;
          w_new_gnt   = 1'b1;
        end
      end
      ACTIVE: begin
        if (!w_holder_valid) begin
          if (w_others_valid) begin
            w_new_gnt = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_hold_nxt  = '0;
          end
        end else if (r_hold == HOLD_LAST) begin
          w_new_gnt = w_others_valid;
        end else begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_hold_nxt  = '0;
      end
    endcase
    if (w_new_gnt) begin
      w_rr_nxt   = w_rr_idx;
      w_hold_nxt = '0;
    end
  end

  always_comb begin
    w_grant_nxt = '0;
    w_id_nxt    = '0;
    w_feat_nxt  = '0;
    if (w_state_nxt == ACTIVE) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (IDX_W'(c) == w_rr_nxt) begin
          w_grant_nxt[c] = 1'b1;
          w_id_nxt       = REQ_ID[c*ID_W +: ID_W];
          w_feat_nxt     = REQ_FEAT[c*FEAT_W +: FEAT_W];
        end
      end
    end
  end

  always_comb begin
    w_conflict = 1'b0;
    for (int a = 0; a < NUM_CH; a++) begin
      for (int b = a + 1; b < NUM_CH; b++) begin
        if (w_valid[a] && w_valid[b] &&
            (REQ_FEAT[a*FEAT_W +: FEAT_W] == REQ_FEAT[b*FEAT_W +: FEAT_W])) begin
          w_conflict = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= IDLE;
      r_rr_ptr    <= RR_RESET;
      r_hold      <= '0;
      r_grant     <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
      r_gnt_feat  <= '0;
      r_conflict  <= 1'b0;
      r_new_gnt   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_hold      <= w_hold_nxt;
      r_grant     <= w_grant_nxt;
      r_gnt_valid <= (w_state_nxt == ACTIVE);
      r_gnt_id    <= w_id_nxt;
      r_gnt_feat  <= w_feat_nxt;
      r_conflict  <= w_conflict;
      r_new_gnt   <= w_new_gnt;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_seg_n <= SEG_BLANK;
    end else begin
      r_seg_n <= r_gnt_valid ? SEG_HEX[4'(r_gnt_id)] : SEG_BLANK;
    end
  end

  assign w_led_target = LED_W'(thermo(4'(r_gnt_feat)));

  led_bar_sweep #(
    .LED_W        (LED_W),
    .SWEEP_CYCLES (SWEEP_CYCLES)
  ) u_led_bar_sweep (
    .clk       (CLK),
    .rst_n     (RST_N),
    .i_target  (w_led_target),
    .i_restart (r_new_gnt),
    .o_led_bar (LED_BAR)
  );

  assign GRANT     = r_grant;
  assign GNT_VALID = r_gnt_valid;
  assign GNT_ID    = r_gnt_id;
  assign GNT_FEAT  = r_gnt_feat;
  assign CONFLICT  = r_conflict;
  assign SEG_N     = r_seg_n;

endmodule
`default_nettype wire

// File: tb/tb_multichannel_entry_arbiter.sv
`default_nettype none
// Bench for multichannel_entry_arbiter (NUM_CH=2, HOLD_CYCLES=4, SWEEP_CYCLES=2).
// Directed scenarios use hand-derived constants; the random run uses a queue-free rule model.
module tb_multichannel_entry_arbiter;

  localparam int NUM_CH = 2;
  localparam int HOLD   = 4;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [1:0] REQ_EN = '0;
  logic [5:0] REQ_ID = '0;
  logic [5:0] REQ_FEAT = '0;
  logic [1:0] GRANT;
  logic       GNT_VALID;
  logic [2:0] GNT_ID;
  logic [2:0] GNT_FEAT;
  logic       CONFLICT;
  logic [6:0] SEG_N;
  logic [6:0] LED_BAR;

  int checks = 0;
  int errors = 0;

  logic [6:0] glyph [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  multichannel_entry_arbiter #(
    .NUM_CH(2), .ID_W(3), .FEAT_W(3), .HOLD_CYCLES(4), .SWEEP_CYCLES(2)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ_EN(REQ_EN), .REQ_ID(REQ_ID), .REQ_FEAT(REQ_FEAT),
    .GRANT(GRANT), .GNT_VALID(GNT_VALID), .GNT_ID(GNT_ID), .GNT_FEAT(GNT_FEAT),
    .CONFLICT(CONFLICT), .SEG_N(SEG_N), .LED_BAR(LED_BAR)
  );

  always #5 CLK = ~CLK;

  // Reference model: holder index (-1 idle), last grantee, cycles held
  int         m_holder, m_rr, m_age, m_nxt;
  logic [2:0] m_id, m_feat;
  logic       m_conf;
  logic [6:0] m_seg, m_led;

  function automatic bit ch_valid(int c);
    return REQ_EN[c] && (REQ_ID[c*3 +: 3] != 0) && (REQ_FEAT[c*3 +: 3] != 0);
  endfunction

  function automatic int pick_next(int rr);
    for (int k = 1; k <= NUM_CH; k++) begin
      if (ch_valid((rr + k) % NUM_CH)) return (rr + k) % NUM_CH;
    end
    return -1;
  endfunction

  function automatic bit other_valid(int holder);
    for (int c = 0; c < NUM_CH; c++) begin
      if (c != holder && ch_valid(c)) return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_holder = -1; m_rr = NUM_CH - 1; m_age = 0;
      m_id = 0; m_feat = 0; m_conf = 0; m_seg = 7'h7F; m_led = 0;
    end else begin
      m_seg = (m_holder >= 0) ? glyph[m_id] : 7'h7F;
      m_led = 7'((8'd1 << m_feat) - 8'd1);
      if (m_holder < 0 || !ch_valid(m_holder) || (m_age == HOLD - 1 && other_valid(m_holder))) begin
        m_nxt = pick_next(m_rr);
        if (m_nxt < 0) begin
          m_holder = -1; m_age = 0;
        end else begin
          m_holder = m_nxt; m_rr = m_nxt; m_age = 0;
        end
      end else if (m_age < HOLD - 1) begin
        m_age = m_age + 1;
      end
      m_id   = (m_holder >= 0) ? REQ_ID[m_holder*3 +: 3] : 3'd0;
      m_feat = (m_holder >= 0) ? REQ_FEAT[m_holder*3 +: 3] : 3'd0;
      m_conf = 1'b0;
      for (int a = 0; a < NUM_CH; a++)
        for (int b = a + 1; b < NUM_CH; b++)
          if (ch_valid(a) && ch_valid(b) && REQ_FEAT[a*3 +: 3] == REQ_FEAT[b*3 +: 3]) m_conf = 1'b1;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_ch(int c, logic en, logic [2:0] id, logic [2:0] feat);
    REQ_EN[c] = en;
    REQ_ID[c*3 +: 3] = id;
    REQ_FEAT[c*3 +: 3] = feat;
  endtask

  task automatic pulse_reset();
    RST_N = 1'b0;
    REQ_EN = '0; REQ_ID = '0; REQ_FEAT = '0;
    tick(2);
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    tick(2);
    checks++; if (GRANT !== 2'b00) begin errors++; $display("FAIL reset_grant got %b want 00", GRANT); end
    checks++; if (GNT_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", GNT_VALID); end
    checks++; if (GNT_ID !== 3'd0) begin errors++; $display("FAIL reset_id got %0d want 0", GNT_ID); end
    checks++; if (GNT_FEAT !== 3'd0) begin errors++; $display("FAIL reset_feat got %0d want 0", GNT_FEAT); end
    checks++; if (CONFLICT !== 1'b0) begin errors++; $display("FAIL reset_conflict got %b want 0", CONFLICT); end
    checks++; if (SEG_N !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h want 7f", SEG_N); end
    checks++; if (LED_BAR !== 7'd0) begin errors++; $display("FAIL reset_led got %b want 0000000", LED_BAR); end
    RST_N = 1'b1;
    tick(1);
  endtask

  task automatic test_single();
    set_ch(0, 1'b1, 3'd5, 3'd3);
    tick(1);
    checks++; if (GRANT !== 2'b01) begin errors++; $display("FAIL single_grant got %b want 01", GRANT); end
    checks++; if (GNT_ID !== 3'd5) begin errors++; $display("FAIL single_id got %0d want 5", GNT_ID); end
    checks++; if (GNT_FEAT !== 3'd3) begin errors++; $display("FAIL single_feat got %0d want 3", GNT_FEAT); end
    checks++; if (SEG_N !== 7'h7F) begin errors++; $display("FAIL single_seg_early got %h want 7f", SEG_N); end
    tick(1);
    checks++; if (SEG_N !== 7'h12) begin errors++; $display("FAIL single_seg got %h want 12", SEG_N); end
    checks++; if (LED_BAR !== 7'b0000111) begin errors++; $display("FAIL single_led got %b want 0000111", LED_BAR); end
    set_ch(0, 1'b0, 3'd5, 3'd3);
    tick(2);
    checks++; if (GNT_VALID !== 1'b0) begin errors++; $display("FAIL single_release got %b want 0", GNT_VALID); end
    checks++; if (SEG_N !== 7'h7F) begin errors++; $display("FAIL single_blank got %h want 7f", SEG_N); end
  endtask

  task automatic test_rotation();
    pulse_reset();
    set_ch(0, 1'b1, 3'd1, 3'd2);
    set_ch(1, 1'b1, 3'd2, 3'd6);
    tick(1);
    checks++; if (GRANT !== 2'b01) begin errors++; $display("FAIL rot_first got %b want 01", GRANT); end
    for (int n = 1; n <= 8; n++) begin
      tick(1);
      checks++;
      if (GRANT !== ((n >= 4 && n < 8) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rot_cycle%0d got %b want %b", n, GRANT, (n >= 4 && n < 8) ? 2'b10 : 2'b01);
      end
      checks++; if (CONFLICT !== 1'b0) begin errors++; $display("FAIL rot_conflict%0d got %b want 0", n, CONFLICT); end
    end
  endtask

  task automatic test_conflict();
    set_ch(0, 1'b1, 3'd1, 3'd4);
    set_ch(1, 1'b1, 3'd2, 3'd4);
    tick(1);
    checks++; if (CONFLICT !== 1'b1) begin errors++; $display("FAIL conflict_set got %b want 1", CONFLICT); end
    set_ch(1, 1'b0, 3'd2, 3'd4);
    tick(1);
    checks++; if (CONFLICT !== 1'b0) begin errors++; $display("FAIL conflict_clear got %b want 0", CONFLICT); end
  endtask

  task automatic test_drop();
    pulse_reset();
    set_ch(0, 1'b1, 3'd1, 3'd2);
    set_ch(1, 1'b1, 3'd2, 3'd5);
    tick(2);
    checks++; if (GRANT !== 2'b01) begin errors++; $display("FAIL drop_pre got %b want 01", GRANT); end
    set_ch(0, 1'b0, 3'd1, 3'd2);
    tick(1);
    checks++; if (GRANT !== 2'b10) begin errors++; $display("FAIL drop_switch got %b want 10", GRANT); end
    set_ch(0, 1'b1, 3'd1, 3'd2);
    for (int n = 1; n <= 4; n++) begin
      tick(1);
      checks++;
      if (GRANT !== ((n < 4) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL drop_hold%0d got %b want %b", n, GRANT, (n < 4) ? 2'b10 : 2'b01);
      end
    end
  endtask

  task automatic test_invalid();
    pulse_reset();
    set_ch(0, 1'b1, 3'd0, 3'd3);
    set_ch(1, 1'b1, 3'd4, 3'd0);
    for (int n = 0; n < 4; n++) begin
      tick(1);
      checks++; if (GNT_VALID !== 1'b0) begin errors++; $display("FAIL invalid_valid got %b want 0", GNT_VALID); end
      checks++; if (GRANT !== 2'b00) begin errors++; $display("FAIL invalid_grant got %b want 00", GRANT); end
      checks++; if (SEG_N !== 7'h7F) begin errors++; $display("FAIL invalid_seg got %h want 7f", SEG_N); end
    end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    set_ch(0, 1'b1, 3'd6, 3'd7);
    set_ch(1, 1'b1, 3'd3, 3'd1);
    tick(3);
    #3;
    RST_N = 1'b0;
    #1;
    checks++; if (GRANT !== 2'b00) begin errors++; $display("FAIL midrst_grant got %b want 00", GRANT); end
    checks++; if (GNT_VALID !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", GNT_VALID); end
    checks++; if (SEG_N !== 7'h7F) begin errors++; $display("FAIL midrst_seg got %h want 7f", SEG_N); end
    checks++; if (LED_BAR !== 7'd0) begin errors++; $display("FAIL midrst_led got %b want 0", LED_BAR); end
    tick(3);
    checks++; if ({GRANT, GNT_ID, GNT_FEAT} !== 8'd0) begin errors++; $display("FAIL midrst_hold got %h want 00", {GRANT, GNT_ID, GNT_FEAT}); end
    RST_N = 1'b1;
    tick(1);
    checks++; if (GRANT !== 2'b01) begin errors++; $display("FAIL midrst_restart got %b want 01", GRANT); end
  endtask

  task automatic test_random();
    logic [1:0] exp_grant;
    pulse_reset();
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(3) == 0) begin
          set_ch(c, ($urandom_range(4) != 0), 3'($urandom_range(7)), 3'($urandom_range(7)));
        end
      end
      tick(1);
      exp_grant = (m_holder >= 0) ? 2'(1 << m_holder) : 2'b00;
      checks++; if (GRANT !== exp_grant) begin errors++; $display("FAIL rnd_grant@%0d got %b want %b", n, GRANT, exp_grant); end
      checks++; if (GNT_VALID !== (m_holder >= 0)) begin errors++; $display("FAIL rnd_valid@%0d got %b want %b", n, GNT_VALID, m_holder >= 0); end
      checks++; if (GNT_ID !== m_id) begin errors++; $display("FAIL rnd_id@%0d got %0d want %0d", n, GNT_ID, m_id); end
      checks++; if (GNT_FEAT !== m_feat) begin errors++; $display("FAIL rnd_feat@%0d got %0d want %0d", n, GNT_FEAT, m_feat); end
      checks++; if (CONFLICT !== m_conf) begin errors++; $display("FAIL rnd_conflict@%0d got %b want %b", n, CONFLICT, m_conf); end
      checks++; if (SEG_N !== m_seg) begin errors++; $display("FAIL rnd_seg@%0d got %h want %h", n, SEG_N, m_seg); end
      checks++; if (LED_BAR !== m_led) begin errors++; $display("FAIL rnd_led@%0d got %b want %b", n, LED_BAR, m_led); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_conflict();
    test_drop();
    test_invalid();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multichannel_entry_arbiter.md
# multichannel_entry_arbiter

Clocked, parametrised successor to the two-interface entry selector. Accepts NUM_CH entry interfaces, each carrying an ID code, a feature code and an enable, and validates each channel. It arbitrates round-robin among valid channels with a minimum hold time and flags feature conflicts. It drives the granted ID to a 7-segment digit and the granted feature to a thermometer LED bar. It sits between the debounced switch/button layer and the board display pins.

## Interface
Parameters:
- NUM_CH, 2, number of entry interfaces (2..8)
- ID_W, 3, ID code width (1..4; one hex digit)
- FEAT_W, 3, feature code width (1..4)
- HOLD_CYCLES, 50000000, minimum cycles a grant is held while other channels wait (>=1)
- SWEEP_CYCLES, 5000000, cycles per LED step in sweep mode (>=1)

Ports:
- CLK  in  1  system clock; one clock domain
- RST_N  in  1  asynchronous, active-low reset
- REQ_EN  in  NUM_CH  per-channel enable, active-high; top level inverts active-low buttons
- REQ_ID  in  NUM_CH*ID_W  channel c ID at bits [c*ID_W +: ID_W]
- REQ_FEAT  in  NUM_CH*FEAT_W  channel c feature at bits [c*FEAT_W +: FEAT_W]
- GRANT  out  NUM_CH  one-hot granted channel; all-zero when idle
- GNT_VALID  out  1  a grant is active
- GNT_ID  out  ID_W  ID of granted channel
- GNT_FEAT  out  FEAT_W  feature of granted channel
- CONFLICT  out  1  two or more valid channels share a feature code
- SEG_N  out  7  segments g..a, active-low
- LED_BAR  out  2**FEAT_W-1  thermometer bar, active-high

## Operation
- Channel c is valid when REQ_EN[c]=1, its ID is nonzero and its feature is nonzero.
- FSM states:
  - IDLE: no valid channel; GRANT=0.
  - ACTIVE: one channel granted; hold counter running.
- IDLE->ACTIVE when any channel is valid. The winner is the first valid index after rr_ptr, with wrap.
- ACTIVE->IDLE when the granted channel becomes invalid and no other channel is valid.
- ACTIVE->ACTIVE with a new grant in two cases:
  - The granted channel becomes invalid while another channel is valid (immediate re-arbitration).
  - Hold counter = HOLD_CYCLES-1 and another channel is valid.
  - On every new grant the hold counter clears.
- Grant with no competitor: the hold counter saturates at HOLD_CYCLES-1 and the grant is kept.
- Round-robin search starts at rr_ptr+1 mod NUM_CH; the current holder is considered last. rr_ptr updates to each new grantee.
- ID or feature change on the granted channel while it stays valid: GNT_ID/GNT_FEAT follow; no re-arbitration.
- CONFLICT is computed over valid channels only, independent of grant.
- SEG_N shows the hex glyph of GNT_ID. It is blank (7'h7F) in IDLE.
- LED_BAR target is GNT_FEAT LEDs lit from bit 0 up; target is 0 in IDLE.

## Timing
- Reset (async assert, sync release):
  - State IDLE, rr_ptr=NUM_CH-1 (channel 0 wins first), counters 0.
  - GRANT=0, GNT_VALID=0, GNT_ID=0, GNT_FEAT=0, CONFLICT=0, SEG_N=7'h7F, LED_BAR=0.
- All outputs are registered.
- GRANT, GNT_VALID, GNT_ID, GNT_FEAT and CONFLICT update on the first edge after an input change (latency 1).
- SEG_N, and LED_BAR without sweep, update one edge after the grant registers (latency 2).
- Reset asserted mid-hold or mid-sweep returns immediately to reset values. There is no resume.

## Configuration
- ENTRY_ARB_SWEEP_EN defined:
  - LED_BAR rises toward target one LED per SWEEP_CYCLES.
  - A lower target takes effect immediately.
  - A grant change restarts the sweep from 0.
- Undefined: LED_BAR equals the target at latency 2, and the sweep counter is not built.

## Structure
- Package entry_arb_pkg:
  - FSM state enum {IDLE, ACTIVE}.
  - 16-entry active-low hex segment constant table.
  - Function for the thermometer code.
- One sub-module: led_bar_sweep. It holds the target register, the sweep counter and the step logic, and is bypassed when ENTRY_ARB_SWEEP_EN is undefined.

## Test plan
All scenarios use NUM_CH=2, HOLD_CYCLES=4, SWEEP_CYCLES=2.
- Reset mid-operation: hold RST_N=0 for 3 cycles during an active grant -> all outputs at reset values the same cycle, SEG_N=7'h7F.
- Channel 0 only, ID=5, FEAT=3:
  - GRANT=01 and GNT_ID=5 after 1 edge.
  - SEG_N=glyph 5 after 2 edges.
  - LED_BAR=0000111 after 2 edges without sweep; after 7 edges with sweep (one step per 2 cycles).
- Both channels valid with FEAT 2 and 6:
  - Ch0 granted first; switches to ch1 after exactly 4 cycles, then back to ch0 after 4 more.
  - CONFLICT=0 throughout.
- Both channels with FEAT=4 -> CONFLICT=1 after 1 edge. Drop ch1 enable -> CONFLICT=0 after 1 edge.
- Granted ch0 drops enable at hold count 1 while ch1 is valid -> GRANT=10 on the next edge, hold counter 0.
- Channel with ID=0 or FEAT=0 and enable=1 -> never granted, GNT_VALID stays 0, SEG_N stays blank.
